// File: rtl/bpu_pkg.sv
// Shared types and counter helpers for the branch target predictor.
package bpu_pkg;

   typedef enum logic {
      BPU_INIT  = 1'b0,
      BPU_READY = 1'b1
   } bpu_state_e;

   // Weakly-taken value: MSB set, all lower bits clear.
   function automatic int unsigned ctr_weak_taken(input int unsigned ctr_w);
      return 32'd1 << (ctr_w - 32'd1);
   endfunction

   function automatic int unsigned ctr_max(input int unsigned ctr_w);
      return (32'd1 << ctr_w) - 32'd1;
   endfunction

endpackage

// File: rtl/bpu_table.sv
// Direct-mapped predictor entry storage: two asynchronous read ports, one synchronous write port.
module bpu_table
   import bpu_pkg::*;
#(
   parameter int IDX_W  = 4,
   parameter int TAG_W  = 6,
   parameter int ADDR_W = 10,
   parameter int CTR_W  = 2
) (
   input  logic              clk,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [ADDR_W-1:0] rd_target,
   output logic [CTR_W-1:0]  rd_ctr,
   input  logic [IDX_W-1:0]  up_idx,
   output logic              up_valid,
   output logic [TAG_W-1:0]  up_tag,
   output logic [ADDR_W-1:0] up_target,
   output logic [CTR_W-1:0]  up_ctr,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic              wr_valid,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [ADDR_W-1:0] wr_target,
   input  logic [CTR_W-1:0]  wr_ctr
);

   localparam int ENTRIES = 2 ** IDX_W;

   logic              valid_mem  [ENTRIES];
   logic [TAG_W-1:0]  tag_mem    [ENTRIES];
   logic [ADDR_W-1:0] target_mem [ENTRIES];
   logic [CTR_W-1:0]  ctr_mem    [ENTRIES];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         valid_mem[wr_idx]  <= wr_valid;
         tag_mem[wr_idx]    <= wr_tag;
         target_mem[wr_idx] <= wr_target;
         ctr_mem[wr_idx]    <= wr_ctr;
      end
   end

   always_comb begin
      rd_valid  = valid_mem[rd_idx];
      rd_tag    = tag_mem[rd_idx];
      rd_target = target_mem[rd_idx];
      rd_ctr    = ctr_mem[rd_idx];
      up_valid  = valid_mem[up_idx];
      up_tag    = tag_mem[up_idx];
      up_target = target_mem[up_idx];
      up_ctr    = ctr_mem[up_idx];
   end

endmodule

// File: rtl/branch_target_predictor.sv
// Tagged branch target predictor with bimodal or gshare indexing, table clear FSM
// and saturating performance counters.
module branch_target_predictor
   import bpu_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int IDX_W  = 4,
   parameter int CTR_W  = 2,
   parameter int GSHARE = 0,
   parameter int PERF_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              lookup_hit,
   output logic              predict_taken,
   output logic [ADDR_W-1:0] predict_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_mispredict,
   output logic              init_busy,
   output logic [PERF_W-1:0] perf_updates,
   output logic [PERF_W-1:0] perf_mispredicts
);

   localparam int TAG_W = ADDR_W - IDX_W;
   localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(ctr_weak_taken(CTR_W));
   localparam logic [CTR_W-1:0] CTR_MAX  = CTR_W'(ctr_max(CTR_W));

   bpu_state_e        state;
   bpu_state_e        state_next;
   logic [IDX_W-1:0]  init_idx;
   logic [IDX_W-1:0]  ghr;

   logic [IDX_W-1:0]  lk_idx;
   logic [TAG_W-1:0]  lk_tag;
   logic [IDX_W-1:0]  u_idx;
   logic [TAG_W-1:0]  u_tag;
   logic              upd_accept;
   logic              up_hit;

   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [ADDR_W-1:0] rd_target;
   logic [CTR_W-1:0]  rd_ctr;
   logic              up_valid;
   logic [TAG_W-1:0]  up_tag;
   logic [ADDR_W-1:0] up_target;
   logic [CTR_W-1:0]  up_ctr;

   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic              wr_valid;
   logic [TAG_W-1:0]  wr_tag;
   logic [ADDR_W-1:0] wr_target;
   logic [CTR_W-1:0]  wr_ctr;

   // ghr stays zero in bimodal mode, so the XOR degenerates to the raw index there.
   always_comb begin
      lk_idx     = lookup_pc[IDX_W-1:0] ^ ghr;
      lk_tag     = lookup_pc[ADDR_W-1:IDX_W];
      u_idx      = upd_pc[IDX_W-1:0] ^ ghr;
      u_tag      = upd_pc[ADDR_W-1:IDX_W];
      upd_accept = upd_valid && (state == BPU_READY) && !rst;
      up_hit     = up_valid && (up_tag == u_tag);
   end

   always_comb begin
      state_next = state;
      case (state)
         BPU_INIT: begin
            if (init_idx == {IDX_W{1'b1}}) begin
               state_next = BPU_READY;
            end else begin
               state_next = BPU_INIT;
            end
         end
         BPU_READY: state_next = BPU_READY;
         default:   state_next = BPU_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= BPU_INIT;
         init_idx         <= '0;
         ghr              <= '0;
         perf_updates     <= '0;
         perf_mispredicts <= '0;
      end else begin
         state <= state_next;
         if (state == BPU_INIT) begin
            init_idx <= init_idx + IDX_W'(1);
         end
         if (upd_accept) begin
            if (GSHARE != 0) begin
               ghr <= {ghr[IDX_W-2:0], upd_taken};
            end
            if (perf_updates != {PERF_W{1'b1}}) begin
               perf_updates <= perf_updates + PERF_W'(1);
            end
            if (upd_mispredict && (perf_mispredicts != {PERF_W{1'b1}})) begin
               perf_mispredicts <= perf_mispredicts + PERF_W'(1);
            end
         end
      end
   end

   // The clear owns the write port during INIT; afterwards it carries update writes.
   always_comb begin
      wr_en     = 1'b0;
      wr_idx    = init_idx;
      wr_valid  = 1'b0;
      wr_tag    = '0;
      wr_target = '0;
      wr_ctr    = '0;
      if (state == BPU_INIT) begin
         wr_en  = 1'b1;
         wr_idx = init_idx;
      end else if (upd_accept) begin
         wr_idx   = u_idx;
         wr_valid = 1'b1;
         wr_tag   = u_tag;
         if (up_hit) begin
            wr_en = 1'b1;
            if (upd_taken) begin
               wr_target = upd_target;
               wr_ctr    = (up_ctr == CTR_MAX) ? CTR_MAX : up_ctr + CTR_W'(1);
            end else begin
               wr_target = up_target;
               wr_ctr    = (up_ctr == '0) ? up_ctr : up_ctr - CTR_W'(1);
            end
         end else if (upd_taken) begin
            wr_en     = 1'b1;
            wr_target = upd_target;
            wr_ctr    = CTR_WEAK;
         end else begin
            wr_en = 1'b0;
         end
      end else begin
         wr_en = 1'b0;
      end
   end

   always_comb begin
      init_busy      = (state == BPU_INIT);
      lookup_hit     = (state == BPU_READY) && rd_valid && (rd_tag == lk_tag);
      predict_taken  = lookup_hit && rd_ctr[CTR_W-1];
      predict_target = lookup_hit ? rd_target : '0;
   end

   bpu_table #(
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .ADDR_W (ADDR_W),
      .CTR_W  (CTR_W)
   ) u_table (
      .clk       (clk),
      .rd_idx    (lk_idx),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_target (rd_target),
      .rd_ctr    (rd_ctr),
      .up_idx    (u_idx),
      .up_valid  (up_valid),
      .up_tag    (up_tag),
      .up_target (up_target),
      .up_ctr    (up_ctr),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .wr_valid  (wr_valid),
      .wr_tag    (wr_tag),
      .wr_target (wr_target),
      .wr_ctr    (wr_ctr)
   );

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: bimodal, gshare and narrow-perf-counter instances driven cycle by cycle.
module tb_branch_target_predictor;

   localparam int S_HIT = 0, S_TAKEN = 1, S_TARGET = 2, S_BUSY = 3, S_PUPD = 4, S_PMIS = 5;
   localparam int S_P_PUPD = 6, S_P_PMIS = 7, S_G_HIT = 8, S_G_TARGET = 9, S_G_BUSY = 10;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] want;
   } sb_item_t;

   sb_item_t sb[$];
   int checks = 0;
   int errors = 0;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] lookup_pc, upd_pc, upd_target;
   logic       upd_valid, upd_taken, upd_mispredict;
   logic       hit, ptaken, busy;
   logic [9:0] ptarget;
   logic [15:0] pupd, pmis;

   logic       p_hit, p_taken, p_busy;
   logic [9:0] p_target;
   logic [1:0] p_pupd, p_pmis;

   logic [9:0] g_lookup_pc, g_upd_pc, g_upd_target;
   logic       g_upd_valid, g_upd_taken;
   logic       g_hit, g_taken, g_busy;
   logic [9:0] g_target;
   logic [15:0] g_pupd, g_pmis;

   always #5 clk = ~clk;

   branch_target_predictor dut (
      .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .lookup_hit(hit),
      .predict_taken(ptaken), .predict_target(ptarget), .upd_valid(upd_valid),
      .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_mispredict(upd_mispredict), .init_busy(busy),
      .perf_updates(pupd), .perf_mispredicts(pmis)
   );

   branch_target_predictor #(.PERF_W(2)) dut_p (
      .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .lookup_hit(p_hit),
      .predict_taken(p_taken), .predict_target(p_target), .upd_valid(upd_valid),
      .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_mispredict(upd_mispredict), .init_busy(p_busy),
      .perf_updates(p_pupd), .perf_mispredicts(p_pmis)
   );

   branch_target_predictor #(.GSHARE(1)) dut_g (
      .clk(clk), .rst(rst), .lookup_pc(g_lookup_pc), .lookup_hit(g_hit),
      .predict_taken(g_taken), .predict_target(g_target), .upd_valid(g_upd_valid),
      .upd_pc(g_upd_pc), .upd_taken(g_upd_taken), .upd_target(g_upd_target),
      .upd_mispredict(1'b0), .init_busy(g_busy),
      .perf_updates(g_pupd), .perf_mispredicts(g_pmis)
   );

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_HIT:      return {31'd0, hit};
         S_TAKEN:    return {31'd0, ptaken};
         S_TARGET:   return {22'd0, ptarget};
         S_BUSY:     return {31'd0, busy};
         S_PUPD:     return {16'd0, pupd};
         S_PMIS:     return {16'd0, pmis};
         S_P_PUPD:   return {30'd0, p_pupd};
         S_P_PMIS:   return {30'd0, p_pmis};
         S_G_HIT:    return {31'd0, g_hit};
         S_G_TARGET: return {22'd0, g_target};
         S_G_BUSY:   return {31'd0, g_busy};
         default:    return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      if (obs !== want) begin
         errors++;
         $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, want);
      end
   endtask

   task automatic push_exp(input string tag, input int sel, input logic [31:0] want);
      sb_item_t it;
      it.tag  = tag;
      it.sel  = sel;
      it.want = want;
      sb.push_back(it);
   endtask

   task automatic drain();
      sb_item_t it;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         check_eq(it.tag, observe(it.sel), it.want);
      end
   endtask

   // Sample on the falling edge, then let the rising edge apply the driven inputs.
   task automatic cyc();
      @(negedge clk);
      drain();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [9:0] pc, input logic tk, input logic [9:0] tgt, input logic mis);
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_taken      = tk;
      upd_target     = tgt;
      upd_mispredict = mis;
   endtask

   task automatic idle();
      upd_valid      = 1'b0;
      upd_mispredict = 1'b0;
   endtask

   task automatic g_upd(input logic [9:0] pc, input logic [9:0] tgt);
      g_upd_valid  = 1'b1;
      g_upd_pc     = pc;
      g_upd_taken  = 1'b1;
      g_upd_target = tgt;
   endtask

   initial begin
      rst = 1'b1;
      lookup_pc = 10'h025; upd_pc = 10'h000; upd_target = 10'h000;
      upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
      g_lookup_pc = 10'h000; g_upd_pc = 10'h000; g_upd_target = 10'h000;
      g_upd_valid = 1'b0; g_upd_taken = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Clear sequence: 16 busy cycles, one ignored update late in the clear.
      for (int i = 0; i < 16; i++) begin
         if (i == 12) upd(10'h025, 1'b1, 10'h100, 1'b1);
         else idle();
         push_exp("init_busy", S_BUSY, 32'd1);
         push_exp("init_hit", S_HIT, 32'd0);
         push_exp("init_taken", S_TAKEN, 32'd0);
         if (i == 0) begin
            push_exp("rst_target", S_TARGET, 32'd0);
            push_exp("rst_pupd", S_PUPD, 32'd0);
            push_exp("rst_pmis", S_PMIS, 32'd0);
         end
         cyc();
      end
      idle();
      push_exp("ready_busy", S_BUSY, 32'd0);
      push_exp("ready_hit", S_HIT, 32'd0);
      push_exp("init_upd_ignored", S_PUPD, 32'd0);
      push_exp("init_mis_ignored", S_PMIS, 32'd0);
      push_exp("g_ready_busy", S_G_BUSY, 32'd0);
      cyc();

      // Allocate on a taken miss; same-cycle lookup sees old contents.
      upd(10'h025, 1'b1, 10'h100, 1'b1);
      push_exp("alloc_same_cycle_hit", S_HIT, 32'd0);
      cyc();
      idle();
      push_exp("alloc_hit", S_HIT, 32'd1);
      push_exp("alloc_taken", S_TAKEN, 32'd1);
      push_exp("alloc_target", S_TARGET, 32'h100);
      push_exp("alloc_pupd", S_PUPD, 32'd1);
      push_exp("alloc_pmis", S_PMIS, 32'd1);
      push_exp("p_pupd_1", S_P_PUPD, 32'd1);
      push_exp("p_pmis_1", S_P_PMIS, 32'd1);
      cyc();
      lookup_pc = 10'h035;
      push_exp("tag_miss_hit", S_HIT, 32'd0);
      push_exp("tag_miss_target", S_TARGET, 32'd0);
      cyc();

      // Counter saturation at max and at zero.
      lookup_pc = 10'h025;
      for (int i = 0; i < 2; i++) begin
         upd(10'h025, 1'b1, 10'h100, 1'b0);
         cyc();
      end
      idle();
      push_exp("ctr_max_taken", S_TAKEN, 32'd1);
      cyc();
      for (int i = 0; i < 3; i++) begin
         upd(10'h025, 1'b0, 10'h3FF, 1'b0);
         cyc();
      end
      idle();
      push_exp("ctr_zero_hit", S_HIT, 32'd1);
      push_exp("ctr_zero_taken", S_TAKEN, 32'd0);
      push_exp("nt_target_kept", S_TARGET, 32'h100);
      cyc();
      upd(10'h025, 1'b0, 10'h3FF, 1'b0);
      cyc();
      upd(10'h025, 1'b1, 10'h100, 1'b0);
      cyc();
      idle();
      push_exp("ctr_min_sat_taken", S_TAKEN, 32'd0);
      push_exp("ctr_min_sat_hit", S_HIT, 32'd1);
      push_exp("pupd_8", S_PUPD, 32'd8);
      push_exp("pmis_1", S_PMIS, 32'd1);
      push_exp("p_pupd_sat", S_P_PUPD, 32'd3);
      push_exp("p_pmis_1b", S_P_PMIS, 32'd1);
      cyc();

      // Not-taken miss writes nothing; same-cycle allocate visible next cycle.
      lookup_pc = 10'h040;
      upd(10'h040, 1'b0, 10'h155, 1'b0);
      cyc();
      idle();
      push_exp("nt_miss_no_alloc", S_HIT, 32'd0);
      cyc();
      lookup_pc = 10'h050;
      upd(10'h050, 1'b1, 10'h2AA, 1'b0);
      push_exp("bypass_old_hit", S_HIT, 32'd0);
      cyc();
      idle();
      push_exp("bypass_new_hit", S_HIT, 32'd1);
      push_exp("bypass_new_taken", S_TAKEN, 32'd1);
      push_exp("bypass_new_target", S_TARGET, 32'h2AA);
      cyc();

      // Mispredict counting; mispredict without upd_valid is not counted.
      lookup_pc = 10'h3F0;
      for (int i = 0; i < 3; i++) begin
         upd(10'h3F0, 1'b1, 10'h011, 1'b1);
         cyc();
      end
      upd_valid = 1'b0;
      upd_mispredict = 1'b1;
      cyc();
      idle();
      push_exp("pupd_13", S_PUPD, 32'd13);
      push_exp("pmis_4", S_PMIS, 32'd4);
      push_exp("p_pupd_sat2", S_P_PUPD, 32'd3);
      push_exp("p_pmis_sat", S_P_PMIS, 32'd3);
      push_exp("hit_3f0", S_HIT, 32'd1);
      push_exp("target_3f0", S_TARGET, 32'h011);
      cyc();

      // Reset mid-operation with an update present, then reset again mid-clear.
      rst = 1'b1;
      upd(10'h025, 1'b1, 10'h155, 1'b1);
      cyc();
      rst = 1'b0;
      idle();
      lookup_pc = 10'h025;
      push_exp("rerst_pupd", S_PUPD, 32'd0);
      push_exp("rerst_pmis", S_PMIS, 32'd0);
      push_exp("rerst_hit", S_HIT, 32'd0);
      for (int i = 0; i < 5; i++) begin
         push_exp("rerst_busy", S_BUSY, 32'd1);
         cyc();
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         push_exp("midinit_busy", S_BUSY, 32'd1);
         push_exp("midinit_hit", S_HIT, 32'd0);
         cyc();
      end
      push_exp("reclear_busy", S_BUSY, 32'd0);
      push_exp("reclear_hit", S_HIT, 32'd0);
      push_exp("reclear_pupd", S_PUPD, 32'd0);
      push_exp("g_reclear_busy", S_G_BUSY, 32'd0);
      cyc();

      // Gshare: updates on 0x001 (idx 1) and 0x002 (idx 2^1=3), ghr becomes 4'b0011.
      g_upd(10'h001, 10'h111);
      cyc();
      g_upd(10'h002, 10'h222);
      cyc();
      g_upd_valid = 1'b0;
      g_lookup_pc = 10'h002;
      push_exp("g_lk002_hit", S_G_HIT, 32'd1);
      push_exp("g_lk002_target", S_G_TARGET, 32'h111);
      cyc();
      g_lookup_pc = 10'h001;
      push_exp("g_lk001_hit", S_G_HIT, 32'd0);
      cyc();
      g_lookup_pc = 10'h000;
      push_exp("g_lk000_hit", S_G_HIT, 32'd1);
      push_exp("g_lk000_target", S_G_TARGET, 32'h222);
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
